cp_remove: RTL and testbench

Receive-side cyclic prefix removal stage. Sits directly downstream of the CP insertion stage (or its channel/ADC equivalent) and upstream of the receive FFT. Each incoming OFDM symbol of `cp_length + frame_length` samples is consumed; the first `cp_length` samples are discarded and the remaining `frame_length` samples are forwarded with an end-of-symbol marker. The output is a registered valid/ready stream with full back-pressure.

---
 rtl/cp_remove.sv | 185 ++++++++++++++++++
 tb/tb_cp_remove.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_remove.sv
// ---------------------------------------------------------------------------
// cp_remove
//
// Receive-side cyclic prefix removal. Each OFDM symbol arrives as
// cp_length + frame_length samples. The first cp_length samples are dropped,
// and the remaining frame_length samples are forwarded on a registered
// valid/ready stream. The last forwarded sample of each symbol carries m_last.
// A LOAD cycle before every symbol latches the lengths. An illegal
// configuration parks the stage in a sticky error state that consumes and
// discards input until reset.
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : asynchronous, active-low reset
//   s_data       : input sample (DATA_W)
//   s_valid      : input sample present
//   s_ready      : stage accepts s_data this cycle
//   cp_length    : prefix length L, sampled only in LOAD
//   frame_length : useful symbol length N, sampled only in LOAD
//   m_data       : registered output sample
//   m_valid      : m_data valid
//   m_ready      : downstream accepts m_data
//   m_last       : marks the N-th output sample of a symbol
//   error        : sticky configuration error (N==0 or L>N)
//   sym_cnt      : number of fully forwarded symbols, wraps
// ---------------------------------------------------------------------------
module cp_remove #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [LEN_W-1:0]  cp_length,
   input  logic [LEN_W-1:0]  frame_length,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              error,
   output logic [LEN_W-1:0]  sym_cnt
);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_CP,
      ST_DATA,
      ST_ERR
   } state_t;

   localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_next;
   logic [LEN_W-1:0]    r_lq;
   logic [LEN_W-1:0]    r_nq;
   logic [LEN_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_mData;
   logic                r_mValid;
   logic                r_mLast;
   logic                r_error;
   logic [LEN_W-1:0]    r_symCnt;

   logic                w_cfgBad;
   logic                w_cpEnd;
   logic                w_dataEnd;
   logic                w_dataRoom;
   logic                w_dataAccept;
   logic                w_outXfer;

   // The configuration is checked against the live inputs because LOAD is the
   // cycle in which they are being latched. L>N is a plain unsigned compare,
   // so no L+N sum is ever formed.
   assign w_cfgBad     = (frame_length == '0) || (cp_length > frame_length);
   assign w_cpEnd      = (r_cnt == r_lq - ONE);
   assign w_dataEnd    = (r_cnt == r_nq - ONE);
   // A data sample can enter when the output register is empty or is being
   // emptied in the same cycle, which gives back-to-back flow with no bubble.
   assign w_dataRoom   = !r_mValid || m_ready;
   assign w_dataAccept = (r_state == ST_DATA) && s_valid && w_dataRoom;
   assign w_outXfer    = r_mValid && m_ready;

   // Next-state and ready decode. LOAD never accepts input, so every symbol
   // costs exactly one bubble cycle.
   always_comb begin
      w_next  = r_state;
      s_ready = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (w_cfgBad) begin
               w_next = ST_ERR;
            end else if (cp_length != '0) begin
               w_next = ST_CP;
            end else begin
               w_next = ST_DATA;
            end
         end
         ST_CP: begin
            s_ready = 1'b1;
            if (s_valid && w_cpEnd) begin
               w_next = ST_DATA;
            end
         end
         ST_DATA: begin
            s_ready = w_dataRoom;
            if (w_dataAccept && w_dataEnd) begin
               w_next = ST_LOAD;
            end
         end
         ST_ERR: begin
            s_ready = 1'b1;
         end
         default: begin
            w_next = ST_LOAD;
         end
      endcase
   end

   // State register, length latches and counters. The prefix counter is
   // reused as the data counter, so it is cleared at the CP to DATA handoff
   // and again in every LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_LOAD;
         r_lq     <= '0;
         r_nq     <= '0;
         r_cnt    <= '0;
         r_error  <= 1'b0;
         r_symCnt <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_LOAD: begin
               r_lq  <= cp_length;
               r_nq  <= frame_length;
               r_cnt <= '0;
               if (w_cfgBad) begin
                  r_error <= 1'b1;
               end
            end
            ST_CP: begin
               if (s_valid) begin
                  r_cnt <= w_cpEnd ? '0 : r_cnt + ONE;
               end
            end
            ST_DATA: begin
               if (w_dataAccept) begin
                  r_cnt <= r_cnt + ONE;
                  if (w_dataEnd) begin
                     r_symCnt <= r_symCnt + ONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output register. It is reloaded only by an accepted data sample, so
   // m_data and m_last hold steady while the downstream stalls. When an
   // accepted sample and a drain happen in the same cycle, the load wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mData  <= '0;
         r_mValid <= 1'b0;
         r_mLast  <= 1'b0;
      end else if (w_dataAccept) begin
         r_mData  <= s_data;
         r_mValid <= 1'b1;
         r_mLast  <= w_dataEnd;
      end else if (w_outXfer) begin
         r_mValid <= 1'b0;
      end
   end

   assign m_data  = r_mData;
   assign m_valid = r_mValid;
   assign m_last  = r_mLast;
   assign error   = r_error;
   assign sym_cnt = r_symCnt;

endmodule

// File: tb/tb_cp_remove.sv
// ---------------------------------------------------------------------------
// tb_cp_remove
//
// Directed bench for cp_remove. Inputs are driven 1 time unit after the
// rising edge. Outputs and handshakes are observed on the falling edge. A
// monitor logs every output transfer so that the main sequence can compare
// the logged stream against hand-built expected streams.
// ---------------------------------------------------------------------------
module tb_cp_remove;

   logic        clk;
   logic        rst;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] cp_length;
   logic [15:0] frame_length;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        error;
   logic [15:0] sym_cnt;

   int          checkCount = 0;
   int          passCount  = 0;
   int          failCount  = 0;
   bit          toggleMode = 1'b0;

   logic [31:0] outQ[$];
   bit          lastQ[$];
   logic [31:0] expD[$];
   bit          expL[$];

   logic        prevStall = 1'b0;
   logic [31:0] prevData  = '0;
   logic        prevLast  = 1'b0;

   cp_remove #(.DATA_W(32), .LEN_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .cp_length    (cp_length),
      .frame_length (frame_length),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last),
      .error        (error),
      .sym_cnt      (sym_cnt)
   );

   // Free-running clock with a 10 time unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: logs output transfers, and checks that the output holds while
   // the downstream stalls.
   always @(negedge clk) begin
      if (rst && prevStall) begin
         checkOutput("stall_valid", {31'b0, m_valid}, 32'd1);
         checkOutput("stall_data", m_data, prevData);
         checkOutput("stall_last", {31'b0, m_last}, {31'b0, prevLast});
      end
      if (rst && m_valid && m_ready) begin
         outQ.push_back(m_data);
         lastQ.push_back(m_last);
      end
      prevStall = rst && m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
   end

   // Advance one clock, optionally toggling m_ready.
   task automatic tick();
      @(posedge clk);
      #1;
      if (toggleMode) m_ready = ~m_ready;
   endtask

   // Present one sample and hold it until accepted. The number of refused
   // cycles is returned in waits, and a fixed budget stops a hang.
   task automatic applyStimulus(input logic [31:0] d, output int waits);
      bit acc;
      waits   = 0;
      s_data  = d;
      s_valid = 1'b1;
      acc     = 1'b0;
      while (!acc && waits < 40) begin
         @(negedge clk);
         acc = s_ready;
         tick();
         if (!acc) waits++;
      end
      if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int n);
      s_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Assert reset, then release it while holding the given configuration.
   // The output queues are cleared along the way.
   task automatic doReset(input logic [15:0] l, input logic [15:0] n);
      rst          = 1'b0;
      s_valid      = 1'b0;
      cp_length    = l;
      frame_length = n;
      @(posedge clk);
      @(posedge clk);
      #1;
      outQ.delete();
      lastQ.delete();
      expD.delete();
      expL.delete();
      rst = 1'b1;
   endtask

   task automatic expectRange(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) begin
         expD.push_back(v);
         expL.push_back(v == hi);
      end
   endtask

   task automatic compareStream(input string tag);
      int n;
      checkOutput({tag, "_count"}, outQ.size(), expD.size());
      n = (outQ.size() < expD.size()) ? outQ.size() : expD.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_data%0d", tag, i), outQ[i], expD[i]);
         checkOutput($sformatf("%s_last%0d", tag, i), {31'b0, lastQ[i]}, {31'b0, expL[i]});
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
      checkOutput({tag, "_m_valid"}, {31'b0, m_valid}, 32'd0);
      checkOutput({tag, "_m_last"}, {31'b0, m_last}, 32'd0);
      checkOutput({tag, "_m_data"}, m_data, 32'd0);
      checkOutput({tag, "_error"}, {31'b0, error}, 32'd0);
      checkOutput({tag, "_sym_cnt"}, {16'b0, sym_cnt}, 32'd0);
   endtask

   initial begin
      int w;
      int waitSum;
      int waitAt0;
      int waitAt12;
      rst          = 1'b0;
      s_data       = '0;
      s_valid      = 1'b0;
      m_ready      = 1'b1;
      cp_length    = '0;
      frame_length = '0;
      #1;

      // Reset values.
      doReset(16'd4, 16'd8);
      rst = 1'b0;
      #1;
      checkResetValues("rst0");

      // L=4, N=8, samples 0..23 streamed with m_ready held high.
      doReset(16'd4, 16'd8);
      waitSum = 0; waitAt0 = 0; waitAt12 = 0;
      for (int i = 0; i < 24; i++) begin
         applyStimulus(i, w);
         waitSum += w;
         if (i == 0) waitAt0 = w;
         if (i == 12) waitAt12 = w;
      end
      drain(3);
      expectRange(4, 11);
      expectRange(16, 23);
      compareStream("t1");
      checkOutput("t1_wait0", waitAt0, 32'd1);
      checkOutput("t1_wait12", waitAt12, 32'd1);
      checkOutput("t1_waitsum", waitSum, 32'd2);
      checkOutput("t1_sym_cnt", {16'b0, sym_cnt}, 32'd2);
      checkOutput("t1_m_valid_end", {31'b0, m_valid}, 32'd0);

      // Same stimulus with m_ready toggling every cycle.
      doReset(16'd4, 16'd8);
      m_ready    = 1'b1;
      toggleMode = 1'b1;
      for (int i = 0; i < 24; i++) applyStimulus(i, w);
      drain(6);
      toggleMode = 1'b0;
      m_ready    = 1'b1;
      drain(2);
      expectRange(4, 11);
      expectRange(16, 23);
      compareStream("t2");
      checkOutput("t2_sym_cnt", {16'b0, sym_cnt}, 32'd2);

      // L=0 passes everything through. L=N forwards only the second half.
      doReset(16'd0, 16'd4);
      for (int i = 0; i < 8; i++) applyStimulus(i, w);
      drain(3);
      expectRange(0, 3);
      expectRange(4, 7);
      compareStream("t3a");

      doReset(16'd4, 16'd4);
      for (int i = 0; i < 8; i++) applyStimulus(i, w);
      drain(3);
      expectRange(4, 7);
      compareStream("t3b");
      checkOutput("t3b_sym_cnt", {16'b0, sym_cnt}, 32'd1);

      // Illegal configurations: L>N, then N=0.
      doReset(16'd9, 16'd8);
      waitSum = 0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(i, w);
         waitSum += w;
      end
      drain(2);
      checkOutput("t4a_error", {31'b0, error}, 32'd1);
      checkOutput("t4a_s_ready", {31'b0, s_ready}, 32'd1);
      checkOutput("t4a_outputs", outQ.size(), 32'd0);
      checkOutput("t4a_waitsum", waitSum, 32'd1);
      checkOutput("t4a_sym_cnt", {16'b0, sym_cnt}, 32'd0);

      doReset(16'd0, 16'd0);
      @(negedge clk);
      checkOutput("t4b_error_in_load", {31'b0, error}, 32'd0);
      #1;
      for (int i = 0; i < 50; i++) applyStimulus(i, w);
      drain(2);
      checkOutput("t4b_error", {31'b0, error}, 32'd1);
      checkOutput("t4b_outputs", outQ.size(), 32'd0);
      checkOutput("t4b_sym_cnt", {16'b0, sym_cnt}, 32'd0);

      // The configuration changes mid-symbol and takes effect at the next LOAD.
      doReset(16'd2, 16'd4);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(i, w);
         if (i == 2) begin
            cp_length    = 16'd1;
            frame_length = 16'd2;
         end
      end
      drain(3);
      expectRange(2, 5);
      expectRange(7, 8);
      compareStream("t5");
      checkOutput("t5_sym_cnt", {16'b0, sym_cnt}, 32'd2);

      // Reset mid-symbol, then a fresh symbol.
      doReset(16'd2, 16'd6);
      for (int i = 1; i <= 5; i++) applyStimulus(i, w);
      checkOutput("t6_pre_valid", {31'b0, m_valid}, 32'd1);
      rst = 1'b0;
      #1;
      checkResetValues("t6_rst");
      doReset(16'd2, 16'd6);
      for (int i = 1; i <= 8; i++) applyStimulus(i, w);
      drain(3);
      expectRange(3, 8);
      compareStream("t6");
      checkOutput("t6_sym_cnt", {16'b0, sym_cnt}, 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
